// File: rtl/mcycle_sequencer.sv
// -----------------------------------------------------------------------------
// mcycle_sequencer
//
// Timing generator for the CPU control unit. It produces the one-hot T-step
// and one-hot M-cycle vectors that the per-opcode microcode blocks decode.
// The M-cycle count restarts at each instruction boundary. The boundary is
// flagged by the active microcode's IR-fetch output. The block also handles
// memory wait states, HALT, and the opcode fetch forced right after reset.
//
// Parameters
//   STEPS   T-steps per M-cycle (width of o_Cycle_Step), must be >= 2
//   COUNTS  maximum M-cycles per instruction (width of o_Cycle_Count)
//
// Ports
//   i_Clk               system clock
//   i_Reset_n           synchronous active-low reset, highest priority
//   i_Clk_En            T-step advance enable; gates every non-reset change
//   i_IR_Fetch          OR of all microcode IR-fetch outputs (last M-cycle)
//   i_Wait              memory not ready; stretches the last T-step
//   i_Halt              HALT decoded; sampled at the instruction boundary
//   i_Interrupt_Pending wakes the block from HALT
//   o_Cycle_Step        one-hot T-step
//   o_Cycle_Count       one-hot M-cycle index within the instruction
//   o_Active            microcode enable (RUN only)
//   o_Boot_Fetch        high during the single M-cycle that follows reset
//   o_Instr_Start       one-clock pulse on the first clock of a new instruction
//   o_Halted            block is in HALT
//   o_Fault             sticky M-cycle count overflow flag
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mcycle_sequencer #(
    parameter int STEPS  = 4,
    parameter int COUNTS = 8
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Clk_En,
    input  logic              i_IR_Fetch,
    input  logic              i_Wait,
    input  logic              i_Halt,
    input  logic              i_Interrupt_Pending,
    output logic [STEPS-1:0]  o_Cycle_Step,
    output logic [COUNTS-1:0] o_Cycle_Count,
    output logic              o_Active,
    output logic              o_Boot_Fetch,
    output logic              o_Instr_Start,
    output logic              o_Halted,
    output logic              o_Fault
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [STEPS-1:0]  STEP_FIRST  = STEPS'(1);
    localparam logic [COUNTS-1:0] COUNT_FIRST = COUNTS'(1);

    state_t            state_q, state_d;
    logic [STEPS-1:0]  step_q, step_d;
    logic [COUNTS-1:0] count_q, count_d;
    logic              fetch_q, fetch_d;
    logic              fault_q, fault_d;
    logic              start_d;

    // Fetch request that applies to this clock. It includes the live
    // i_IR_Fetch so that microcode can raise fetch on the final T-step.
    // BOOT always requests a fetch, which ends BOOT after one M-cycle.
    logic fetch_now;
    logic step_last;
    logic wait_hold;
    logic mcycle_end;

    always_comb begin
        fetch_now  = fetch_q
                   | (state_q == ST_BOOT)
                   | ((state_q == ST_RUN) & i_IR_Fetch);
        step_last  = step_q[STEPS-1];
        // Wait only takes effect on the last T-step.
        wait_hold  = step_last & i_Wait;
        mcycle_end = step_last & ~i_Wait;
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        fetch_d = fetch_q;
        fault_d = fault_q;
        start_d = 1'b0;

        if (i_Clk_En) begin
            unique case (state_q)
                ST_BOOT, ST_RUN: begin
                    if (!wait_hold)
                        step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};

                    fetch_d = fetch_now;

                    if (mcycle_end) begin
                        fetch_d = 1'b0;
                        if (fetch_now) begin
                            // Instruction boundary.
                            count_d = COUNT_FIRST;
                            if (i_Halt) begin
                                state_d = ST_HALT;
                            end else begin
                                state_d = ST_RUN;
                                start_d = 1'b1;
                            end
                        end else if (count_q[COUNTS-1]) begin
                            // The microcode never asserted fetch. Record the
                            // fault and treat this as a boundary so that the
                            // sequencer keeps cycling.
                            fault_d = 1'b1;
                            count_d = COUNT_FIRST;
                            start_d = 1'b1;
                        end else begin
                            count_d = count_q << 1;
                        end
                    end
                end

                ST_HALT: begin
                    step_d  = STEP_FIRST;
                    count_d = COUNT_FIRST;
                    fetch_d = 1'b0;
                    if (i_Interrupt_Pending) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                    step_d  = STEP_FIRST;
                    count_d = COUNT_FIRST;
                    fetch_d = 1'b0;
                end
            endcase
        end
    end

    // State register. The status outputs are decoded from next-state so
    // that they change on the same edge as the state.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q       <= ST_BOOT;
            step_q        <= STEP_FIRST;
            count_q       <= COUNT_FIRST;
            fetch_q       <= 1'b0;
            fault_q       <= 1'b0;
            o_Active      <= 1'b0;
            o_Boot_Fetch  <= 1'b1;
            o_Instr_Start <= 1'b0;
            o_Halted      <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            count_q       <= count_d;
            fetch_q       <= fetch_d;
            fault_q       <= fault_d;
            o_Active      <= (state_d == ST_RUN);
            o_Boot_Fetch  <= (state_d == ST_BOOT);
            o_Instr_Start <= start_d;
            o_Halted      <= (state_d == ST_HALT);
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_Fault       = fault_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcycle_sequencer
//
// Directed bench for mcycle_sequencer. Before each clock, the expected
// post-edge state is pushed to a scoreboard queue. It is popped and compared
// field by field 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_mcycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       ir_fetch;
    logic       wait_in;
    logic       halt;
    logic       intr;
    logic [3:0] step;
    logic [7:0] count;
    logic       active;
    logic       boot_fetch;
    logic       instr_start;
    logic       halted;
    logic       fault;

    int n_assert = 0;
    int n_fail   = 0;
    int n_edge   = 0;

    typedef struct {
        string      tag;
        logic [3:0] step;
        logic [7:0] count;
        logic       active;
        logic       boot;
        logic       start;
        logic       halted;
        logic       fault;
    } exp_t;

    exp_t sb[$];

    mcycle_sequencer #(.STEPS(4), .COUNTS(8)) dut (
        .i_Clk               (clk),
        .i_Reset_n           (rst_n),
        .i_Clk_En            (clk_en),
        .i_IR_Fetch          (ir_fetch),
        .i_Wait              (wait_in),
        .i_Halt              (halt),
        .i_Interrupt_Pending (intr),
        .o_Cycle_Step        (step),
        .o_Cycle_Count       (count),
        .o_Active            (active),
        .o_Boot_Fetch        (boot_fetch),
        .o_Instr_Start       (instr_start),
        .o_Halted            (halted),
        .o_Fault             (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Push the expectation, advance one clock, then pop and compare.
    task automatic edge_chk(input string tag, input logic [3:0] s, input logic [7:0] c,
                            input logic a, input logic b, input logic st,
                            input logic h, input logic f);
        exp_t e;
        e.tag = $sformatf("%s@%0d", tag, n_edge);
        e.step = s; e.count = c; e.active = a; e.boot = b;
        e.start = st; e.halted = h; e.fault = f;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_edge++;
        e = sb.pop_front();
        chk({e.tag, ".step"},   {4'h0, step},         {4'h0, e.step});
        chk({e.tag, ".count"},  count,                e.count);
        chk({e.tag, ".active"}, {7'h0, active},       {7'h0, e.active});
        chk({e.tag, ".boot"},   {7'h0, boot_fetch},   {7'h0, e.boot});
        chk({e.tag, ".start"},  {7'h0, instr_start},  {7'h0, e.start});
        chk({e.tag, ".halted"}, {7'h0, halted},       {7'h0, e.halted});
        chk({e.tag, ".fault"},  {7'h0, fault},        {7'h0, e.fault});
    endtask

    // One plain RUN M-cycle that starts at step 0001 of count c.
    task automatic mcyc(input string tag, input logic [7:0] c, input logic [7:0] c_next,
                        input logic st_next, input logic f, input logic f_next);
        edge_chk(tag, 4'b0010, c, 1'b1, 1'b0, 1'b0, 1'b0, f);
        edge_chk(tag, 4'b0100, c, 1'b1, 1'b0, 1'b0, 1'b0, f);
        edge_chk(tag, 4'b1000, c, 1'b1, 1'b0, 1'b0, 1'b0, f);
        edge_chk(tag, 4'b0001, c_next, 1'b1, 1'b0, st_next, 1'b0, f_next);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; ir_fetch = 1'b0;
        wait_in = 1'b0; halt = 1'b0; intr = 1'b0;

        // Reset values
        edge_chk("reset", 4'b0001, 8'h01, 0, 1, 0, 0, 0);
        edge_chk("reset", 4'b0001, 8'h01, 0, 1, 0, 0, 0);
        rst_n = 1'b1;

        // BOOT: one M-cycle, then RUN with a start pulse
        edge_chk("boot", 4'b0010, 8'h01, 0, 1, 0, 0, 0);
        edge_chk("boot", 4'b0100, 8'h01, 0, 1, 0, 0, 0);
        edge_chk("boot", 4'b1000, 8'h01, 0, 1, 0, 0, 0);
        edge_chk("boot", 4'b0001, 8'h01, 1, 0, 1, 0, 0);

        // 5-M-cycle instruction with fetch held during count 0x10
        mcyc("i5", 8'h01, 8'h02, 0, 0, 0);
        mcyc("i5", 8'h02, 8'h04, 0, 0, 0);
        mcyc("i5", 8'h04, 8'h08, 0, 0, 0);
        mcyc("i5", 8'h08, 8'h10, 0, 0, 0);
        ir_fetch = 1'b1;
        mcyc("i5", 8'h10, 8'h01, 1, 0, 0);
        ir_fetch = 1'b0;

        // Wait is ignored at 0010 and holds for 3 clocks at 1000 (7 clocks total)
        mcyc("w", 8'h01, 8'h02, 0, 0, 0);
        edge_chk("w", 4'b0010, 8'h02, 1, 0, 0, 0, 0);
        wait_in = 1'b1;
        edge_chk("w_s2", 4'b0100, 8'h02, 1, 0, 0, 0, 0);
        wait_in = 1'b0;
        edge_chk("w", 4'b1000, 8'h02, 1, 0, 0, 0, 0);
        wait_in = 1'b1;
        for (int i = 0; i < 3; i++)
            edge_chk("w_hold", 4'b1000, 8'h02, 1, 0, 0, 0, 0);
        wait_in = 1'b0;
        edge_chk("w_end", 4'b0001, 8'h04, 1, 0, 0, 0, 0);

        // HALT at the boundary, frozen for 10 clocks, interrupt resumes
        ir_fetch = 1'b1; halt = 1'b1;
        edge_chk("h", 4'b0010, 8'h04, 1, 0, 0, 0, 0);
        edge_chk("h", 4'b0100, 8'h04, 1, 0, 0, 0, 0);
        edge_chk("h", 4'b1000, 8'h04, 1, 0, 0, 0, 0);
        edge_chk("h_enter", 4'b0001, 8'h01, 0, 0, 0, 1, 0);
        ir_fetch = 1'b0; halt = 1'b0;
        for (int i = 0; i < 10; i++)
            edge_chk("h_dwell", 4'b0001, 8'h01, 0, 0, 0, 1, 0);
        intr = 1'b1;
        edge_chk("h_exit", 4'b0001, 8'h01, 1, 0, 1, 0, 0);
        intr = 1'b0;

        // Clock enable low: everything holds, and the start pulse drops
        clk_en = 1'b0;
        edge_chk("ce0", 4'b0001, 8'h01, 1, 0, 0, 0, 0);
        edge_chk("ce0", 4'b0001, 8'h01, 1, 0, 0, 0, 0);
        clk_en = 1'b1;
        edge_chk("ce", 4'b0010, 8'h01, 1, 0, 0, 0, 0);
        edge_chk("ce", 4'b0100, 8'h01, 1, 0, 0, 0, 0);
        clk_en = 1'b0;
        edge_chk("ce0_mid", 4'b0100, 8'h01, 1, 0, 0, 0, 0);
        edge_chk("ce0_mid", 4'b0100, 8'h01, 1, 0, 0, 0, 0);
        clk_en = 1'b1;
        edge_chk("ce", 4'b1000, 8'h01, 1, 0, 0, 0, 0);
        edge_chk("ce", 4'b0001, 8'h02, 1, 0, 0, 0, 0);

        // Halt and interrupt together: a single-clock HALT dwell
        ir_fetch = 1'b1; halt = 1'b1; intr = 1'b1;
        edge_chk("hi", 4'b0010, 8'h02, 1, 0, 0, 0, 0);
        edge_chk("hi", 4'b0100, 8'h02, 1, 0, 0, 0, 0);
        edge_chk("hi", 4'b1000, 8'h02, 1, 0, 0, 0, 0);
        edge_chk("hi_enter", 4'b0001, 8'h01, 0, 0, 0, 1, 0);
        ir_fetch = 1'b0; halt = 1'b0;
        edge_chk("hi_exit", 4'b0001, 8'h01, 1, 0, 1, 0, 0);
        intr = 1'b0;

        // Count overflow without fetch: sticky fault plus a boundary
        for (int i = 0; i < 7; i++)
            mcyc("ovf", 8'(1 << i), 8'(1 << (i + 1)), 0, 0, 0);
        mcyc("ovf_end", 8'h80, 8'h01, 1, 0, 1);
        mcyc("ovf_sticky", 8'h01, 8'h02, 0, 1, 1);
        mcyc("ovf_sticky", 8'h02, 8'h04, 0, 1, 1);

        // Reset mid-M-cycle with wait high restores all reset values
        edge_chk("r", 4'b0010, 8'h04, 1, 0, 0, 0, 1);
        edge_chk("r", 4'b0100, 8'h04, 1, 0, 0, 0, 1);
        wait_in = 1'b1; rst_n = 1'b0;
        edge_chk("r_mid", 4'b0001, 8'h01, 0, 1, 0, 0, 0);
        clk_en = 1'b0;
        edge_chk("r_noce", 4'b0001, 8'h01, 0, 1, 0, 0, 0);
        rst_n = 1'b1; wait_in = 1'b0; clk_en = 1'b1;
        edge_chk("r_boot", 4'b0010, 8'h01, 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
# mcycle_sequencer

Timing generator for the CPU control unit. It produces the one-hot T-step (`o_Cycle_Step`) and one-hot M-cycle (`o_Cycle_Count`) vectors that every per-opcode microcode block decodes. It restarts the M-cycle count at each instruction boundary signalled by the active microcode's IR-fetch output, and it supports memory wait states, HALT, and a first fetch after reset.

## Interface
Parameters:
- `STEPS`, 4: T-steps per M-cycle. Width of `o_Cycle_Step`.
- `COUNTS`, 8: maximum M-cycles per instruction. Width of `o_Cycle_Count`.

Ports:
- `i_Clk`, in, 1: single system clock.
- `i_Reset_n`, in, 1: reset. Synchronous, active-low.
- `i_Clk_En`, in, 1: T-step advance enable. All state changes except reset require it high.
- `i_IR_Fetch`, in, 1: OR of all microcode `o_IR_Fetch` outputs. Marks the current M-cycle as the last of the instruction.
- `i_Wait`, in, 1: memory not ready. Stretches step 3.
- `i_Halt`, in, 1: HALT opcode decoded. Sampled at the instruction boundary.
- `i_Interrupt_Pending`, in, 1: wakes the block from HALT.
- `o_Cycle_Step`, out, STEPS: one-hot T-step.
- `o_Cycle_Count`, out, COUNTS: one-hot M-cycle index within the instruction.
- `o_Active`, out, 1: microcode enable. It feeds every microcode `i_Active` through the opcode decoder AND.
- `o_Boot_Fetch`, out, 1: high during the first M-cycle after reset. It forces an opcode fetch.
- `o_Instr_Start`, out, 1: one-clock pulse when a new instruction's M-cycle 0 begins.
- `o_Halted`, out, 1: the block is in the HALT state.
- `o_Fault`, out, 1: sticky flag for M-cycle count overflow.

## Operation
- States: BOOT, RUN, HALT.
- Reset values: BOOT, step=0001, count=0x01, `o_Active`=0, `o_Boot_Fetch`=1, `o_Instr_Start`=0, `o_Halted`=0, `o_Fault`=0, fetch latch=0.
- Step rotation: on each enabled clock, the step rotates left 0001→0010→0100→1000→0001.
- Wait states: with step=1000 and `i_Wait`=1, the step holds at 1000 and count holds. Wait is ignored on the other steps.
- Fetch latch:
  - Set when `i_IR_Fetch` is high on any enabled clock in RUN, or when the block is in BOOT.
  - Cleared at every M-cycle end. An M-cycle end is the enabled 1000→0001 transition.
- M-cycle end with the fetch latch set:
  - If `i_Halt`=1, go to HALT.
  - Otherwise count←0x01, `o_Instr_Start` pulses for the next clock, and the state becomes RUN (this also applies when leaving BOOT).
- M-cycle end with the fetch latch clear: count shifts left one bit.
- Overflow: at an M-cycle end with count[COUNTS-1]=1 and the fetch latch clear:
  - `o_Fault`←1.
  - count←0x01 and the block behaves as an instruction boundary, so `o_Instr_Start` pulses.
- `o_Active`: 1 only in RUN. It is 0 in BOOT and HALT, so no microcode acts.
- HALT behaviour:
  - step and count are frozen at 0001 and 0x01. `o_Halted`=1.
  - On an enabled clock with `i_Interrupt_Pending`=1, go to RUN with step=0001, count=0x01, and `o_Instr_Start` pulsing.
  - `i_Interrupt_Pending` already high at HALT entry gives a HALT dwell of exactly one enabled clock.
- Simultaneous `i_Halt` and `i_Interrupt_Pending` at the boundary: enter HALT, then exit on the next enabled clock.
- `i_Reset_n`=0 on any clock, including mid-M-cycle, during wait, or in HALT: restores the reset values on that clock edge. Reset has priority over everything.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- One T-step per enabled clock. An M-cycle takes 4 enabled clocks plus one per wait clock.
- An instruction of N M-cycles has count values 0x01…(1<<(N-1)). The microcode asserts fetch during the last of these, and the next clock after that M-cycle's end shows count=0x01.
- `o_Instr_Start` is high exactly on the first clock of step=0001, count=0x01 of each instruction. It is never high in BOOT or HALT.
- BOOT lasts exactly one M-cycle, 4 enabled clocks without wait. `o_Boot_Fetch` falls with the transition to RUN.
- With `i_Clk_En`=0, every register holds, except that the one-clock pulse `o_Instr_Start` deasserts.

## Test plan
- Reset, then `i_Clk_En`=1 continuously: step cycles 1,2,4,8. After 4 clocks the state is RUN, count=0x01, `o_Instr_Start`=1 for one clock, `o_Boot_Fetch` goes 1→0, and `o_Active` goes 0→1.
- 5-M-cycle instruction with `i_IR_Fetch` held during count=0x10: counts 0x01,0x02,0x04,0x08,0x10 each last 4 clocks, then count=0x01 with an `o_Instr_Start` pulse.
- `i_Wait`=1 for 3 clocks at step=1000, count=0x02: step holds at 8 and count holds at 0x02 for those 3 clocks, and the M-cycle totals 7 clocks. `i_Wait` high at step=0010 has no effect.
- `i_Halt`=1 with `i_IR_Fetch` in the last M-cycle: `o_Halted`=1, `o_Active`=0, step=0001, count=0x01 frozen for 10 clocks. Then `i_Interrupt_Pending`=1 resumes RUN on the next clock with an `o_Instr_Start` pulse.
- No `i_IR_Fetch` for 8 M-cycles: after count=0x80 ends, `o_Fault`=1 sticky and count=0x01. `o_Fault` clears only on reset.
- `i_Reset_n`=0 at step=0100, count=0x04, with `i_Wait` also high: the next clock shows all reset values. Toggling `i_Clk_En`=0 freezes the step mid-sequence.
